gate_logic_unit: RTL



---
 rtl/gate_logic_unit.sv | 74 +++++++
 1 files changed

// File: rtl/gate_logic_unit.sv
// Registered, opcode-selected bitwise gate engine with valid/ready handshake,
// accumulate mode, zero/ones status flags and a saturating beat counter.
module gate_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_ones,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A seed beat (acc_clear) takes in1 even in accumulate mode.
    assign opa = (acc_mode && !acc_clear) ? acc : in1;

    always_comb begin
        res = '0;
        case (op)
            3'd0: res = opa & in2;
            3'd1: res = opa | in2;
            3'd2: res = ~(opa | in2);
            3'd3: res = ~(opa & in2);
            3'd4: res = opa ^ in2;
            3'd5: res = ~(opa ^ in2);
            3'd6: res = opa;
            3'd7: res = ~opa;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_zero  <= 1'b0;
            out_ones  <= 1'b0;
            acc       <= '0;
            count     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= res;
            out_zero  <= (res == '0);
            out_ones  <= (res == '1);
            if (acc_mode) begin
                acc <= res;
            end
            if (count != '1) begin
                count <= count + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
